hilo_unit: RTL and testbench



---
 rtl/hilo_params_pkg.sv | 32 +++
 rtl/hilo_unit_multiplier.sv | 50 +++++
 rtl/hilo_unit.sv | 173 +++++++++++++++++
 tb/tb_hilo_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_params_pkg.sv
// hilo_params: shared types for the HI/LO execute-stage controller.
//   CPU_DATA_WIDTH : operand and HI/LO register width
//   cpu_data_t     : one data word
//   hilo_op_t      : HI/LO operation codes from the execute stage
//   hilo_state_t   : controller states. ZERO_WB is only reachable when the
//                    design is built with DIV_ZERO_FAST_EN defined.
package hilo_params;

    localparam int CPU_DATA_WIDTH = 32;

    typedef logic [CPU_DATA_WIDTH-1:0] cpu_data_t;

    typedef enum logic [2:0] {
        HILO_NONE  = 3'd0,
        HILO_MULT  = 3'd1,
        HILO_MULTU = 3'd2,
        HILO_DIV   = 3'd3,
        HILO_DIVU  = 3'd4,
        HILO_MTHI  = 3'd5,
        HILO_MTLO  = 3'd6
    } hilo_op_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_WAIT  = 3'd1,
        DIV_ISSUE = 3'd2,
        DIV_WAIT  = 3'd3,
        DRAIN     = 3'd4,
        ZERO_WB   = 3'd5
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit_multiplier.sv
// hilo_multiplier: registered 33x33 signed multiply, one-cycle latency.
// Each 32-bit operand is sign-extended (signed op) or zero-extended
// (unsigned op) to 33 bits, so one signed multiplier covers MULT and MULTU.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_load           : capture a new product at this edge
//   i_is_signed      : 1 = MULT, 0 = MULTU
//   i_a, i_b         : multiplicand, multiplier
//   o_product        : registered {hi, lo} product
module hilo_multiplier
    import hilo_params::*;
(
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_load,
    input  logic                        i_is_signed,
    input  cpu_data_t                   i_a,
    input  cpu_data_t                   i_b,
    output logic [2*CPU_DATA_WIDTH-1:0] o_product
);

    localparam int W = CPU_DATA_WIDTH;

    logic [W:0]     w_ext_a;
    logic [W:0]     w_ext_b;
    logic [2*W-1:0] w_wide_a;
    logic [2*W-1:0] w_wide_b;
    logic [2*W-1:0] w_product;
    logic [2*W-1:0] r_product;

    assign w_ext_a = {i_is_signed & i_a[W-1], i_a};
    assign w_ext_b = {i_is_signed & i_b[W-1], i_b};

    // Widening the 33-bit values to the full result width keeps the low
    // 2*W bits of the product identical to a true 33x33 signed multiply.
    assign w_wide_a  = {{(W-1){w_ext_a[W]}}, w_ext_a};
    assign w_wide_b  = {{(W-1){w_ext_b[W]}}, w_ext_b};
    assign w_product = w_wide_a * w_wide_b;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_product <= '0;
        end else if (i_load) begin
            r_product <= w_product;
        end
    end

    assign o_product = r_product;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: execute-stage owner of the HI/LO registers. Runs MULT/MULTU
// locally, hands DIV/DIVU to an external divider, and applies MTHI/MTLO
// immediately. hilo_busy interlocks MFHI/MFLO while a result is pending.
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor bypasses the
// divider and writes lo=all-ones, hi=dividend one cycle later.
// Ports:
//   clock, reset            : core clock, synchronous active-high reset
//   op_valid, op, src1, src2: incoming HI/LO operation and operands
//   flush                   : cancel the in-flight op
//   op_ready, hilo_busy     : accept / interlock status
//   hi, lo                  : architectural HI/LO
//   div_request_valid, div_is_signed, div_input1, div_input2 : divider issue
//   div_result_valid, div_result, div_remain                 : divider return
//
// state     | meaning
// IDLE      | ready for a new op; MTHI/MTLO write here
// MUL_WAIT  | product registered, written to {hi,lo} at the next edge
// DIV_ISSUE | request pulse to the divider this cycle
// DIV_WAIT  | waiting for the divider strobe, operands held
// DRAIN     | flushed divide still running; result will be discarded
// ZERO_WB   | zero-divisor fast path write-back (DIV_ZERO_FAST_EN only)
module hilo_unit
    import hilo_params::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      op_valid,
    input  hilo_op_t  op,
    input  cpu_data_t src1,
    input  cpu_data_t src2,
    input  logic      flush,
    output logic      op_ready,
    output logic      hilo_busy,
    output cpu_data_t hi,
    output cpu_data_t lo,
    output logic      div_request_valid,
    output logic      div_is_signed,
    output cpu_data_t div_input1,
    output cpu_data_t div_input2,
    input  logic      div_result_valid,
    input  cpu_data_t div_result,
    input  cpu_data_t div_remain
);

    localparam int W = CPU_DATA_WIDTH;

    hilo_state_t    r_state;
    hilo_state_t    w_state_next;
    cpu_data_t      r_hi;
    cpu_data_t      r_lo;
    cpu_data_t      r_div_in1;
    cpu_data_t      r_div_in2;
    logic           r_div_signed;
    logic           w_accept;
    logic           w_is_mul;
    logic           w_is_div;
    logic           w_zero_div;
    logic [2*W-1:0] w_product;

    assign w_accept = (r_state == IDLE) && op_valid && !flush;
    assign w_is_mul = (op == HILO_MULT) || (op == HILO_MULTU);
    assign w_is_div = (op == HILO_DIV)  || (op == HILO_DIVU);

`ifdef DIV_ZERO_FAST_EN
    assign w_zero_div = (src2 == '0);
`else
    assign w_zero_div = 1'b0;
`endif

    hilo_multiplier u_mult (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_load     (w_accept && w_is_mul),
        .i_is_signed(op == HILO_MULT),
        .i_a        (src1),
        .i_b        (src2),
        .o_product  (w_product)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_next = MUL_WAIT;
                    end else if (w_is_div) begin
                        w_state_next = w_zero_div ? ZERO_WB : DIV_ISSUE;
                    end
                end
            end
            MUL_WAIT:  w_state_next = IDLE;
            // The divider samples the request this cycle, so a flush here
            // must still wait for its result.
            DIV_ISSUE: w_state_next = flush ? DRAIN : DIV_WAIT;
            DIV_WAIT: begin
                if (div_result_valid) begin
                    w_state_next = IDLE;
                end else if (flush) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (div_result_valid) begin
                    w_state_next = IDLE;
                end
            end
            ZERO_WB:   w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_in1    <= '0;
            r_div_in2    <= '0;
            r_div_signed <= 1'b0;
        end else if (w_accept && w_is_div) begin
            r_div_in1    <= src1;
            r_div_in2    <= src2;
            r_div_signed <= (op == HILO_DIV);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && op == HILO_MTHI) r_hi <= src1;
                    if (w_accept && op == HILO_MTLO) r_lo <= src1;
                end
                MUL_WAIT: begin
                    if (!flush) {r_hi, r_lo} <= w_product;
                end
                DIV_WAIT: begin
                    if (div_result_valid && !flush) begin
                        r_lo <= div_result;
                        r_hi <= div_remain;
                    end
                end
                ZERO_WB: begin
                    if (!flush) begin
                        r_lo <= '1;
                        r_hi <= r_div_in1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign op_ready          = (r_state == IDLE);
    assign hilo_busy         = (r_state != IDLE);
    assign hi                = r_hi;
    assign lo                = r_lo;
    assign div_request_valid = (r_state == DIV_ISSUE);
    assign div_is_signed     = r_div_signed;
    assign div_input1        = r_div_in1;
    assign div_input2        = r_div_in2;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
    import hilo_params::*;

    logic      clock;
    logic      reset;
    logic      op_valid;
    hilo_op_t  op;
    cpu_data_t src1;
    cpu_data_t src2;
    logic      flush;
    logic      op_ready;
    logic      hilo_busy;
    cpu_data_t hi;
    cpu_data_t lo;
    logic      div_request_valid;
    logic      div_is_signed;
    cpu_data_t div_input1;
    cpu_data_t div_input2;
    logic      div_result_valid;
    cpu_data_t div_result;
    cpu_data_t div_remain;

    int errors = 0;
    int checks = 0;
    int n_pulse = 0;

    hilo_unit dut (
        .clock            (clock),
        .reset            (reset),
        .op_valid         (op_valid),
        .op               (op),
        .src1             (src1),
        .src2             (src2),
        .flush            (flush),
        .op_ready         (op_ready),
        .hilo_busy        (hilo_busy),
        .hi               (hi),
        .lo               (lo),
        .div_request_valid(div_request_valid),
        .div_is_signed    (div_is_signed),
        .div_input1       (div_input1),
        .div_input2       (div_input2),
        .div_result_valid (div_result_valid),
        .div_result       (div_result),
        .div_remain       (div_remain)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (!reset && div_request_valid) n_pulse = n_pulse + 1;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic issue(input hilo_op_t o, input cpu_data_t a, input cpu_data_t b);
        op_valid = 1'b1;
        op       = o;
        src1     = a;
        src2     = b;
        tick();
        op_valid = 1'b0;
        op       = HILO_NONE;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op_valid = 1'b0; op = HILO_NONE; src1 = '0; src2 = '0; flush = 1'b0;
        div_result_valid = 1'b0; div_result = '0; div_remain = '0;
        repeat (3) tick();
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got=%b want=1", op_ready); end
        checks++; if (hilo_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", hilo_busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
        checks++; if (div_request_valid !== 1'b0) begin errors++; $display("FAIL reset_div_req got=%b want=0", div_request_valid); end
        checks++; if (div_input1 !== 32'h0 || div_input2 !== 32'h0) begin errors++; $display("FAIL reset_div_inputs got=%h/%h want=0/0", div_input1, div_input2); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        issue(HILO_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        checks++; if (hilo_busy !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL mult_busy got=%b/%b want=1/0", hilo_busy, op_ready); end
        tick();
        checks++; if (hilo_busy !== 1'b0) begin errors++; $display("FAIL mult_done got=%b want=0", hilo_busy); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_result got=%h_%h want=ffffffff_fffffffe", hi, lo); end
        issue(HILO_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        tick();
        checks++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_result got=%h_%h want=00000001_fffffffe", hi, lo); end
        issue(HILO_MULT, 32'h8000_0000, 32'h8000_0000);
        tick();
        checks++; if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin errors++; $display("FAIL mult_minmin got=%h_%h want=40000000_00000000", hi, lo); end
        issue(HILO_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        tick();
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg got=%h_%h want=ffffffff_ffffffeb", hi, lo); end
    endtask

    task automatic test_divu();
        int start;
        start = n_pulse;
        issue(HILO_DIVU, 32'd100, 32'd7);
        checks++; if (div_request_valid !== 1'b1) begin errors++; $display("FAIL divu_req got=%b want=1", div_request_valid); end
        checks++; if (div_input1 !== 32'd100 || div_input2 !== 32'd7 || div_is_signed !== 1'b0) begin errors++; $display("FAIL divu_operands got=%h/%h/%b want=64/7/0", div_input1, div_input2, div_is_signed); end
        tick();
        checks++; if (div_request_valid !== 1'b0 || div_input1 !== 32'd100 || div_input2 !== 32'd7) begin errors++; $display("FAIL divu_hold got=%b %h/%h want=0 64/7", div_request_valid, div_input1, div_input2); end
        repeat (3) tick();
        div_result_valid = 1'b1; div_result = 32'd14; div_remain = 32'd2;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL divu_ready_at_strobe got=%b want=0", op_ready); end
        tick();
        div_result_valid = 1'b0;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL divu_ready_after got=%b want=1", op_ready); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_result got=%h_%h want=00000002_0000000e", hi, lo); end
        checks++; if (n_pulse - start !== 1) begin errors++; $display("FAIL divu_pulses got=%0d want=1", n_pulse - start); end
    endtask

    task automatic test_div_signed();
        logic busy_ok;
        busy_ok = 1'b1;
        issue(HILO_DIV, 32'hFFFF_FFF9, 32'd2);
        checks++; if (div_is_signed !== 1'b1) begin errors++; $display("FAIL div_signed got=%b want=1", div_is_signed); end
        for (int i = 0; i < 4; i++) begin
            if (hilo_busy !== 1'b1) busy_ok = 1'b0;
            tick();
        end
        if (hilo_busy !== 1'b1) busy_ok = 1'b0;
        div_result_valid = 1'b1; div_result = 32'hFFFF_FFFD; div_remain = 32'hFFFF_FFFF;
        tick();
        div_result_valid = 1'b0;
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL div_busy_throughout got=%b want=1", busy_ok); end
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_result got=%h_%h want=ffffffff_fffffffd", hi, lo); end
    endtask

    task automatic test_mthi_mtlo();
        op_valid = 1'b1; op = HILO_MTHI; src1 = 32'h1234_5678;
        tick();
        checks++; if (hi !== 32'h1234_5678 || op_ready !== 1'b1) begin errors++; $display("FAIL mthi got=%h rdy=%b want=12345678 rdy=1", hi, op_ready); end
        op = HILO_MTLO; src1 = 32'h9ABC_DEF0;
        tick();
        op_valid = 1'b0; op = HILO_NONE;
        checks++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo got=%h_%h want=12345678_9abcdef0", hi, lo); end
    endtask

    task automatic test_flush_drain();
        int start;
        issue(HILO_MTHI, 32'h0000_1111, 32'h0);
        issue(HILO_MTLO, 32'h0000_2222, 32'h0);
        start = n_pulse;
        issue(HILO_DIV, 32'd50, 32'd5);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (hilo_busy !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL drain_busy got=%b/%b want=1/0", hilo_busy, op_ready); end
        op_valid = 1'b1; op = HILO_DIVU; src1 = 32'd9; src2 = 32'd4;
        repeat (2) tick();
        checks++; if (n_pulse - start !== 1 || op_ready !== 1'b0) begin errors++; $display("FAIL drain_no_accept pulses=%0d rdy=%b want=1/0", n_pulse - start, op_ready); end
        div_result_valid = 1'b1; div_result = 32'hDEAD; div_remain = 32'hBEEF;
        tick();
        div_result_valid = 1'b0;
        checks++; if (hi !== 32'h0000_1111 || lo !== 32'h0000_2222) begin errors++; $display("FAIL drain_discard got=%h_%h want=00001111_00002222", hi, lo); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL drain_to_idle got=%b want=1", op_ready); end
        tick();
        op_valid = 1'b0; op = HILO_NONE;
        checks++; if (div_request_valid !== 1'b1 || div_input1 !== 32'd9 || div_input2 !== 32'd4) begin errors++; $display("FAIL drain_fresh_req got=%b %h/%h want=1 9/4", div_request_valid, div_input1, div_input2); end
        tick();
        div_result_valid = 1'b1; div_result = 32'd2; div_remain = 32'd1;
        tick();
        div_result_valid = 1'b0;
        checks++; if (lo !== 32'd2 || hi !== 32'd1 || n_pulse - start !== 2) begin errors++; $display("FAIL drain_next_div got=%h_%h pulses=%0d want=1_2 pulses=2", hi, lo, n_pulse - start); end
    endtask

    task automatic test_flush_with_strobe();
        issue(HILO_DIVU, 32'd8, 32'd3);
        tick();
        flush = 1'b1; div_result_valid = 1'b1; div_result = 32'h5555; div_remain = 32'h6666;
        tick();
        flush = 1'b0; div_result_valid = 1'b0;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL flush_strobe_idle got=%b want=1", op_ready); end
        checks++; if (hi !== 32'd1 || lo !== 32'd2) begin errors++; $display("FAIL flush_strobe_discard got=%h_%h want=1_2", hi, lo); end
    endtask

    task automatic test_ignored_ops();
        flush = 1'b1;
        issue(HILO_MTHI, 32'hAAAA_AAAA, 32'h0);
        flush = 1'b0;
        checks++; if (hi !== 32'd1 || op_ready !== 1'b1) begin errors++; $display("FAIL idle_flush got=%h rdy=%b want=1 rdy=1", hi, op_ready); end
        issue(hilo_op_t'(3'd7), 32'hAAAA_AAAA, 32'h3);
        checks++; if (op_ready !== 1'b1 || hi !== 32'd1 || lo !== 32'd2) begin errors++; $display("FAIL invalid_op got=%h_%h rdy=%b want=1_2 rdy=1", hi, lo, op_ready); end
        issue(HILO_MULT, 32'd3, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (op_ready !== 1'b1 || hi !== 32'd1 || lo !== 32'd2) begin errors++; $display("FAIL mul_flush got=%h_%h rdy=%b want=1_2 rdy=1", hi, lo, op_ready); end
    endtask

    task automatic test_div_zero();
        int start;
        start = n_pulse;
        issue(HILO_DIV, 32'd5, 32'd0);
`ifdef DIV_ZERO_FAST_EN
        checks++; if (hilo_busy !== 1'b1 || div_request_valid !== 1'b0) begin errors++; $display("FAIL zero_fast_busy got=%b req=%b want=1 req=0", hilo_busy, div_request_valid); end
        tick();
        checks++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF || n_pulse - start !== 0) begin errors++; $display("FAIL zero_fast got=%h_%h pulses=%0d want=5_ffffffff pulses=0", hi, lo, n_pulse - start); end
`else
        checks++; if (div_request_valid !== 1'b1 || div_input2 !== 32'd0) begin errors++; $display("FAIL zero_issue got=%b %h want=1 0", div_request_valid, div_input2); end
        tick();
        div_result_valid = 1'b1; div_result = 32'hAAAA_5555; div_remain = 32'd5;
        tick();
        div_result_valid = 1'b0;
        checks++; if (hi !== 32'd5 || lo !== 32'hAAAA_5555 || n_pulse - start !== 1) begin errors++; $display("FAIL zero_divider got=%h_%h pulses=%0d want=5_aaaa5555 pulses=1", hi, lo, n_pulse - start); end
`endif
    endtask

    initial begin
        tick();
        test_reset();
        test_mult();
        test_divu();
        test_div_signed();
        test_mthi_mtlo();
        test_flush_drain();
        test_flush_with_strobe();
        test_ignored_ops();
        test_div_zero();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
